regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port general register file for the superscalar MIPS core. Successor to the single-write, dual-read GPR array.
- Configurable read-port count, write-port count, data width and depth.
- Byte-strobed writes with port priority.
- Per-register pending scoreboard for issue-stage hazard detection.
- Per-write-port difftest/debug trace.
- Sits between decode/issue (read, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two.
- ADDR_W, $clog2(DEPTH), register index width (derived; do not override).
- NUM_RD, 4, number of combinational read ports.
- NUM_WR, 2, number of write ports; higher index = younger instruction.
- ZERO_REG, 1, 1: register 0 reads as zero and ignores writes; 0: register 0 is ordinary storage.

Ports:
- clk  in  1  core clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  pending bit of the addressed register per read port.
- wr_en  in  NUM_WR  write request per port.
- wr_addr  in  NUM_WR*ADDR_W  write index per port.
- wr_be  in  NUM_WR*(DATA_W/8)  byte enables per port.
- wr_data  in  NUM_WR*DATA_W  write data per port.
- wr_clr  in  NUM_WR  clear the pending bit of wr_addr (final write of producer).
- sb_set_en  in  NUM_WR  mark a register pending (issue of a producer).
- sb_set_addr  in  NUM_WR*ADDR_W  register to mark.
- dbg_pc  in  NUM_WR*32  PC of the instruction on each write port.
- debug_wb_pc  out  NUM_WR*32  registered trace PC.
- debug_wb_rf_wen  out  NUM_WR*(DATA_W/8)  registered effective byte enables.
- debug_wb_rf_wnum  out  NUM_WR*ADDR_W  registered write index.
- debug_wb_rf_wdata  out  NUM_WR*DATA_W  registered write data.

Behaviour:
- Reset, asynchronous, while resetn=0:
  - all registers = 0; all pending bits = 0;
  - all debug_* outputs = 0.
  - rd_data/rd_busy are combinational and therefore read 0 during reset.
  - Reset asserted mid-write discards that write.
- Write:
  - Port i is effective when wr_en[i]=1 and !(ZERO_REG && wr_addr[i]==0).
  - Byte b of the target register takes wr_data byte b when wr_be byte b=1; other bytes are unchanged.
  - The result is visible on rd_data one cycle later (same cycle under the optional feature).
- Same-address writes in one cycle: merged per byte. For each byte, the highest-indexed port with that byte enabled wins. wr_be=0 with wr_en=1 is a legal no-op write, but wr_clr still applies.
- Read:
  - rd_data[k] = register[rd_addr[k]], purely combinational.
  - With ZERO_REG=1, address 0 reads 0 regardless of stored state.
- Scoreboard:
  - sb_set_en[i] sets pending[sb_set_addr[i]] at the clock edge.
  - An effective write with wr_clr[i]=1 clears pending[wr_addr[i]].
  - Set and clear of the same register in the same cycle: set wins (newer producer).
  - Setting or clearing register 0 under ZERO_REG=1 is ignored; pending[0] stays 0.
  - rd_busy[k] = pending[rd_addr[k]].
- Debug trace: registered one cycle after the write edge.
  - debug_wb_rf_wen[i] = wr_be[i] when the write is effective, else 0.
  - wnum, wdata and pc are copied unconditionally.

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- Defined:
  - Each read port forwards the same-cycle merged effective write data, byte-wise, for any byte being written to rd_addr[k]. Non-written bytes come from storage.
  - rd_busy[k] is masked to 0 when a wr_clr to rd_addr[k] occurs this cycle and no sb_set to that address occurs this cycle.
- Undefined: reads and busy reflect storage state only; a write is observed one cycle later.

Decomposition:
- Package regfile_mp_pkg holds:
  - default width constants: DATA_W_DEF=32, DEPTH_DEF=32;
  - function merge_bytes(old, new, be);
  - function prio_sel for byte-wise port priority.
- One sub-module, regfile_mp_sb: pending-bit array with set/clear ports and read lookup. It is shared by the FPU/CP0 register files later.
- Storage, write merge, bypass and trace stay in the top.

Test Plan:
- Reset, then read all 32 addresses on 4 ports -> rd_data=0, rd_busy=0, debug_wb_rf_wen=0.
- Port0 writes r5=0x12345678 with be=0xF; read r5 next cycle -> 0x12345678. Then port1 writes be=0x2, data 0x0000AB00 -> r5=0x1234AB78. Trace wen=0x2, wnum=5.
- Port0 and port1 write r7 in the same cycle: p0 0x11111111 be=0xF, p1 0x22222222 be=0x3 -> r7=0x11112222.
- Write r0=0xFFFFFFFF with ZERO_REG=1 -> reads 0, trace wen=0. sb_set r0 -> rd_busy stays 0.
- sb_set r9, then next cycle: rd_busy=1. Write r9 with wr_clr=1 plus a same-cycle sb_set r9 -> rd_busy remains 1. A later clear alone -> 0.
- With REGFILE_MP_BYPASS_EN: write r3=0xDEADBEEF and read r3 in the same cycle -> rd_data=0xDEADBEEF combinationally, and rd_busy=0 if wr_clr=1. Without the macro: old value, new value next cycle.
- Assert resetn=0 asynchronously mid-cycle during a write -> state zeroes immediately; the write is lost after release.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and byte-lane helpers for the multi-port register file.
// The helpers work on fixed maximum widths so any legal DATA_W/NUM_WR can
// call them. Callers cast arguments and results to their own widths.
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32;

  // Upper bounds for the generic helpers below.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE     = MAX_DATA_W / 8;
  localparam int unsigned MAX_PORTS  = 16;

  // Replace each byte of old_v whose enable is set with the same byte of new_v.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BE-1:0]     be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int unsigned b = 0; b < MAX_BE; b++) begin
      if (be[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Index of the highest requesting port (the youngest instruction).
  // Returns 0 when nothing requests, so callers qualify the result with |req.
  function automatic int unsigned prio_sel(input logic [MAX_PORTS-1:0] req);
    int unsigned sel;
    sel = 0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (req[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-bit scoreboard: one bit per register, set at issue, cleared by the
// producer's final write, with combinational lookup per read port.
// Also intended for reuse by the FPU and CP0 register files.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_SET  = 2,
  parameter int unsigned NUM_CLR  = 2,
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_SET-1:0]        set_en,
  input  logic [NUM_SET*ADDR_W-1:0] set_addr,
  input  logic [NUM_CLR-1:0]        clr_en,
  input  logic [NUM_CLR*ADDR_W-1:0] clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]         rd_busy
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next pending state: clears first, then sets, so a newer producer wins.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NUM_CLR; i++) begin
      if (clr_en[i]) pend_d[clr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_SET; i++) begin
      if (set_en[i]) pend_d[set_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  // Pending-bit storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // Per-port busy lookup.
  always_comb begin
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = pend_q[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NUM_RD combinational reads, NUM_WR byte-strobed writes
// with younger-port-wins merging, a pending scoreboard and a registered
// writeback trace. Define REGFILE_MP_BYPASS_EN to forward same-cycle writes
// (and same-cycle scoreboard clears) to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*(DATA_W/8)-1:0]  wr_be,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  input  logic [NUM_WR-1:0]             wr_clr,
  input  logic [NUM_WR-1:0]             sb_set_en,
  input  logic [NUM_WR*ADDR_W-1:0]      sb_set_addr,
  input  logic [NUM_WR*32-1:0]          dbg_pc,
  output logic [NUM_WR*32-1:0]          debug_wb_pc,
  output logic [NUM_WR*(DATA_W/8)-1:0]  debug_wb_rf_wen,
  output logic [NUM_WR*ADDR_W-1:0]      debug_wb_rf_wnum,
  output logic [NUM_WR*DATA_W-1:0]      debug_wb_rf_wdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_WR-1:0]        wr_eff;
  logic [NUM_WR-1:0]        sb_clr_en;
  logic [NUM_RD-1:0]        sb_busy;
  logic [NUM_WR*32-1:0]     trc_pc_q,    trc_pc_d;
  logic [NUM_WR*BE_W-1:0]   trc_wen_q,   trc_wen_d;
  logic [NUM_WR*ADDR_W-1:0] trc_wnum_q,  trc_wnum_d;
  logic [NUM_WR*DATA_W-1:0] trc_wdata_q, trc_wdata_d;

  // Merged write lanes aimed at addr: per byte, the youngest enabled port wins.
  function automatic void lane_fwd(
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NUM_WR-1:0]        eff,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*BE_W-1:0]   wbe,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]        fwd_v,
    output logic [BE_W-1:0]          fwd_be
  );
    logic [NUM_WR-1:0] hit;
    int unsigned       sel;
    fwd_v  = '0;
    fwd_be = '0;
    sel    = 0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      hit = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        hit[i] = eff[i] && (waddr[i*ADDR_W +: ADDR_W] == addr) && wbe[i*BE_W + b];
      end
      if (|hit) begin
        sel       = prio_sel(MAX_PORTS'(hit));
        fwd_be[b] = 1'b1;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
          if (i == sel) fwd_v[b*8 +: 8] = wdata[i*DATA_W + b*8 +: 8];
        end
      end
    end
  endfunction

  // Effective writes: requested, not aimed at a hardwired r0, and not in reset.
  always_comb begin
    wr_eff = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      wr_eff[i] = resetn && wr_en[i] &&
                  !((ZERO_REG != 0) && (wr_addr[i*ADDR_W +: ADDR_W] == '0));
    end
    sb_clr_en = wr_eff & wr_clr;
  end

  // Next storage state with all write ports merged byte-wise.
  always_comb begin : write_merge
    logic [DATA_W-1:0] new_v;
    logic [BE_W-1:0]   new_be;
    new_v  = '0;
    new_be = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      lane_fwd(ADDR_W'(r), wr_eff, wr_addr, wr_be, wr_data, new_v, new_be);
      mem_d[r] = DATA_W'(merge_bytes(MAX_DATA_W'(mem_q[r]), MAX_DATA_W'(new_v),
                                     MAX_BE'(new_be)));
    end
  end

  // Next trace state: byte enables only for effective writes, rest copied.
  always_comb begin
    trc_wen_d = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      trc_wen_d[i*BE_W +: BE_W] = wr_eff[i] ? wr_be[i*BE_W +: BE_W] : '0;
    end
    trc_pc_d    = dbg_pc;
    trc_wnum_d  = wr_addr;
    trc_wdata_d = wr_data;
  end

  // Register storage and writeback trace.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q       <= '{default: '0};
      trc_pc_q    <= '0;
      trc_wen_q   <= '0;
      trc_wnum_q  <= '0;
      trc_wdata_q <= '0;
    end else begin
      mem_q       <= mem_d;
      trc_pc_q    <= trc_pc_d;
      trc_wen_q   <= trc_wen_d;
      trc_wnum_q  <= trc_wnum_d;
      trc_wdata_q <= trc_wdata_d;
    end
  end

  assign debug_wb_pc       = trc_pc_q;
  assign debug_wb_rf_wen   = trc_wen_q;
  assign debug_wb_rf_wnum  = trc_wnum_q;
  assign debug_wb_rf_wdata = trc_wdata_q;

  regfile_mp_sb #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NUM_SET  (NUM_WR),
    .NUM_CLR  (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .resetn   (resetn),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .clr_en   (sb_clr_en),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy)
  );

  // Read ports: storage lookup, optional same-cycle forwarding, r0 forced to zero.
  always_comb begin : read_ports
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
`ifdef REGFILE_MP_BYPASS_EN
    logic [DATA_W-1:0] fv;
    logic [BE_W-1:0]   fbe;
    logic              clr_hit;
    logic              set_hit;
    fv      = '0;
    fbe     = '0;
    clr_hit = 1'b0;
    set_hit = 1'b0;
`endif
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    v       = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a          = rd_addr[k*ADDR_W +: ADDR_W];
      v          = mem_q[a];
      rd_busy[k] = sb_busy[k];
`ifdef REGFILE_MP_BYPASS_EN
      lane_fwd(a, wr_eff, wr_addr, wr_be, wr_data, fv, fbe);
      v = DATA_W'(merge_bytes(MAX_DATA_W'(v), MAX_DATA_W'(fv), MAX_BE'(fbe)));
      clr_hit = 1'b0;
      set_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
        if (sb_clr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == a))    clr_hit = 1'b1;
        if (sb_set_en[i] && (sb_set_addr[i*ADDR_W +: ADDR_W] == a)) set_hit = 1'b1;
      end
      if (clr_hit && !set_hit) rd_busy[k] = 1'b0;
`endif
      if ((ZERO_REG != 0) && (a == '0)) v = '0;
      rd_data[k*DATA_W +: DATA_W] = v;
    end
  end

endmodule
